// File: rtl/matmul_mem_pkg.sv
// Shared definitions for the matmul scratchpad memory server.
package matmul_mem_pkg;

    localparam int unsigned DefaultDepth   = 64;
    localparam int unsigned DefaultLatency = 2;
    localparam int unsigned WordWidth      = 32;

    // Engine-side transaction sequencing.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_t;

endpackage

// File: rtl/matmul_sp_ram.sv
// Single-port synchronous scratchpad RAM, write-first read-during-write.
module matmul_sp_ram
    import matmul_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [WordWidth-1:0] wdata,
    output logic [WordWidth-1:0] rdata
);

    logic [WordWidth-1:0] mem [DEPTH];

    // Storage array and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/matmul_mem_server.sv
// Scratchpad server: fixed-latency engine port plus opportunistic host port.
module matmul_mem_server
    import matmul_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned LATENCY = DefaultLatency
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_start,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     req_done,
    output logic [31:0]              req_rdata,
    input  logic                     host_en,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [31:0]              host_wdata,
    output logic                     host_ready,
    output logic [31:0]              host_rdata,
    output logic                     err,
    output logic [15:0]              txn_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;

    logic          we_q;
    logic          bad_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;

    logic [31:0]   rdata_hold_q;
    logic          err_q;
    logic [15:0]   txn_q;
    logic          host_pend_q;
    logic [31:0]   host_hold_q;

    logic          accept;
    logic          req_bad;
    logic [AW-1:0] req_idx;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    assign req_idx    = req_addr[2 +: AW];
    assign req_bad    = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH));
    assign accept     = (state_q == StIdle) && req_start;
    assign host_ready = (state_q == StIdle) && !req_start;

    // Next-state: WAIT lasts LATENCY-1 cycles, skipped entirely when LATENCY is 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_start) begin
                    if (LATENCY == 1) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'd1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'(LATENCY - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the engine request on acceptance; datapath only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            bad_q   <= req_bad;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
        end
    end

    // RAM port arbitration. The engine read is issued while waiting (or at
    // acceptance) so the registered RAM output lines up with the DONE cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (req_start) begin
                        ram_en   = 1'b1;
                        ram_addr = req_idx;
                    end else if (host_en) begin
                        ram_en = 1'b1;
                        ram_we = host_we;
                    end
                end
                StWait: begin
                    ram_en   = 1'b1;
                    ram_addr = idx_q;
                end
                StDone: begin
                    if (we_q && !bad_q) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = idx_q;
                        ram_wdata = wdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion bookkeeping and held read data for both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold_q <= 32'd0;
            err_q        <= 1'b0;
            txn_q        <= 16'd0;
            host_pend_q  <= 1'b0;
            host_hold_q  <= 32'd0;
        end else begin
            if (state_q == StDone) begin
                txn_q <= txn_q + 16'd1;
                if (bad_q) begin
                    err_q        <= 1'b1;
                    rdata_hold_q <= 32'd0;
                end else if (!we_q) begin
                    rdata_hold_q <= ram_rdata;
                end
            end
            host_pend_q <= host_en && host_ready && !host_we;
            if (host_pend_q) begin
                host_hold_q <= ram_rdata;
            end
        end
    end

    // Outputs: fresh RAM data in its valid cycle, held copy afterwards.
    always_comb begin
        req_done   = (state_q == StDone);
        req_rdata  = rdata_hold_q;
        if (req_done && bad_q) begin
            req_rdata = 32'd0;
        end else if (req_done && !we_q) begin
            req_rdata = ram_rdata;
        end
        host_rdata = host_pend_q ? ram_rdata : host_hold_q;
        err        = err_q;
        txn_count  = txn_q;
    end

    matmul_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/matmul_mem_server.md
MATMUL_MEM_SERVER -- requirements
Module: matmul_mem_server

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the scratchpad (power of two, 4..256).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to completion (1..15).
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_start  in  1  engine request strobe (matrix multiply engine side).
REQ-006 req_we  in  1  1 = write, 0 = read; sampled with req_start.
REQ-007 req_addr  in  32  byte address; sampled with req_start.
REQ-008 req_wdata  in  32  write data; sampled with req_start.
REQ-009 req_done  out  1  one-cycle completion pulse.
REQ-010 req_rdata  out  32  read data; valid with req_done, held until the next completion.
REQ-011 host_en  in  1  host preload/readback access strobe.
REQ-012 host_we  in  1  host write enable.
REQ-013 host_addr  in  log2(DEPTH)  host word index.
REQ-014 host_wdata  in  32  host write data.
REQ-015 host_ready  out  1  host access accepted this cycle when high.
REQ-016 host_rdata  out  32  host read data, valid the cycle after an accepted host read.
REQ-017 err  out  1  sticky bad-address flag.
REQ-018 txn_count  out  16  completed engine transactions, wraps 0xFFFF->0.

Function
REQ-019 States IDLE, WAIT, DONE: IDLE->WAIT on req_start; WAIT->DONE after LATENCY-1 cycles in WAIT (LATENCY=1: IDLE->DONE directly); DONE->IDLE unconditionally.
REQ-020 A request is accepted only when req_start=1 in IDLE; req_we/addr/wdata captured that cycle; req_start in WAIT or DONE is ignored.
REQ-021 Accept in cycle t -> req_done=1 in exactly cycle t+LATENCY, 0 at all other times.
REQ-022 Word index = req_addr[2+:log2(DEPTH)]; an address is bad if req_addr[1:0]!=0 or req_addr >= 4*DEPTH.
REQ-023 Good write: RAM[index] <= wdata at the completion cycle; req_rdata unchanged.
REQ-024 Good read: req_rdata = RAM[index] as of the completion cycle.
REQ-025 Bad address: no RAM access, req_rdata=0, err set to 1, req_done still pulses.
REQ-026 txn_count increments by 1 on every req_done, including bad-address completions.
REQ-027 host_ready = (state==IDLE) && !req_start, combinational; the engine wins same-cycle contention and the host retries.
REQ-028 Accepted host write updates RAM next edge; accepted host read drives host_rdata next cycle; host_rdata holds otherwise.
REQ-029 Host access with host_ready=0 has no effect.
REQ-030 Back-to-back engine requests: req_start high in the DONE cycle is ignored; the earliest next acceptance is cycle t+LATENCY+1.

Reset
REQ-031 On rst: state=IDLE, req_done=0, req_rdata=0, host_rdata=0, err=0, txn_count=0.
REQ-032 Reset mid-transaction abandons it: no RAM write and no req_done pulse.
REQ-033 RAM contents are not reset.

Structure
REQ-034 Package matmul_mem_pkg SHALL hold the state encoding and the default DEPTH/LATENCY constants.
REQ-035 Storage SHALL be one sub-module matmul_sp_ram: single-port synchronous RAM, DEPTH x 32, write-first, with the engine/host mux in this block.

Verification
REQ-036 Host writes words 0..17 with values 1..18; engine reads addr 0x0,0x44 -> rdata 1 and 18, req_done exactly 2 cycles after each accept.
REQ-037 Engine write addr 0x8 data 0xDEADBEEF, then host reads index 2 -> host_rdata 0xDEADBEEF the next cycle.
REQ-038 Engine read addr 0x6 then addr 0x100 (DEPTH=64) -> both req_done pulse, rdata 0, err=1 and stays 1, txn_count=2.
REQ-039 req_start and host_en high together in IDLE -> host_ready=0, host write to index 5 not performed, engine accepted.
REQ-040 Engine write accepted, rst asserted in WAIT -> no req_done, RAM word unchanged, all outputs at reset values.
REQ-041 req_start held high for 20 cycles with LATENCY=2 -> req_done pulses every 3 cycles, txn_count advances by 1 per pulse.
